// File: rtl/gcd_control_unit_if.sv
// Handshake and status bundle between the GCD control unit and its user/datapath side.
// The slave modport is the control unit; the master modport drives Enter and the datapath flags.
interface gcd_control_unit_if #(
    parameter int ITER_W = 8
);
    logic              Enter;
    logic              InZero;
    logic              XeqY;
    logic              XgtY;
    logic              LoadX;
    logic              LoadY;
    logic              SubXY;
    logic              SubYX;
    logic              OutEn;
    logic              Halt;
    logic              Error;
    logic [ITER_W-1:0] IterCount;
    logic [3:0]        State;

    modport master (
        output Enter,
        output InZero,
        output XeqY,
        output XgtY,
        input  LoadX,
        input  LoadY,
        input  SubXY,
        input  SubYX,
        input  OutEn,
        input  Halt,
        input  Error,
        input  IterCount,
        input  State
    );

    modport slave (
        input  Enter,
        input  InZero,
        input  XeqY,
        input  XgtY,
        output LoadX,
        output LoadY,
        output SubXY,
        output SubYX,
        output OutEn,
        output Halt,
        output Error,
        output IterCount,
        output State
    );
endinterface

// File: rtl/gcd_control_unit.sv
// Control FSM for the subtract-and-compare GCD datapath: operand capture, subtraction
// sequencing with an iteration limit, and result/error reporting.
module gcd_control_unit #(
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255
) (
    input  logic             Clock,
    input  logic             Reset,
    gcd_control_unit_if.slave bus
);

    typedef enum logic [3:0] {
        ST_INIT    = 4'd0,
        ST_WAITX   = 4'd1,
        ST_WAITY   = 4'd2,
        ST_COMPARE = 4'd3,
        ST_SUBX    = 4'd4,
        ST_SUBY    = 4'd5,
        ST_DONE    = 4'd6,
        ST_ERR     = 4'd7
    } state_t;

    localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);

    state_t            state_r;
    state_t            next_state_s;
    logic              enter_q_r;
    logic              enter_rise_s;
    logic [ITER_W-1:0] iter_count_r;

    logic              load_x_s;
    logic              load_y_s;
    logic              sub_xy_s;
    logic              sub_yx_s;
    logic              out_en_s;
    logic              halt_s;
    logic              error_s;

    logic              sub_xy_r;
    logic              sub_yx_r;
    logic              out_en_r;
    logic              halt_r;
    logic              error_r;

    // State register and Enter edge-detect history; EnterQ resets high so a held Enter is ignored.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r   <= ST_INIT;
            enter_q_r <= 1'b1;
        end else begin
            state_r   <= next_state_s;
            enter_q_r <= bus.Enter;
        end
    end

    // Rising-edge detect and Mealy operand-load strobes.
    always_comb begin
        enter_rise_s = bus.Enter & ~enter_q_r;
        load_x_s     = 1'b0;
        load_y_s     = 1'b0;
        if (state_r == ST_WAITX) begin
            load_x_s = enter_rise_s & ~bus.InZero;
        end else if (state_r == ST_WAITY) begin
            load_y_s = enter_rise_s & ~bus.InZero;
        end else begin
            load_x_s = 1'b0;
            load_y_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = ST_INIT;
        case (state_r)
            ST_INIT: begin
                next_state_s = ST_WAITX;
            end
            ST_WAITX: begin
                if (enter_rise_s) begin
                    next_state_s = bus.InZero ? ST_ERR : ST_WAITY;
                end else begin
                    next_state_s = ST_WAITX;
                end
            end
            ST_WAITY: begin
                if (enter_rise_s) begin
                    next_state_s = bus.InZero ? ST_ERR : ST_COMPARE;
                end else begin
                    next_state_s = ST_WAITY;
                end
            end
            ST_COMPARE: begin
                // Equality wins over the limit: a run that converges on its last allowed step succeeds.
                if (bus.XeqY) begin
                    next_state_s = ST_DONE;
                end else if (iter_count_r == MAX_ITER_C) begin
                    next_state_s = ST_ERR;
                end else if (bus.XgtY) begin
                    next_state_s = ST_SUBX;
                end else begin
                    next_state_s = ST_SUBY;
                end
            end
            ST_SUBX: begin
                next_state_s = ST_COMPARE;
            end
            ST_SUBY: begin
                next_state_s = ST_COMPARE;
            end
            ST_DONE: begin
                if (enter_rise_s) begin
                    next_state_s = ST_WAITX;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            ST_ERR: begin
                if (enter_rise_s) begin
                    next_state_s = ST_WAITX;
                end else begin
                    next_state_s = ST_ERR;
                end
            end
            default: begin
                next_state_s = ST_INIT;
            end
        endcase
    end

    // Moore output decode, taken from the next state so the registered copies line up with State.
    always_comb begin
        sub_xy_s = 1'b0;
        sub_yx_s = 1'b0;
        out_en_s = 1'b0;
        halt_s   = 1'b0;
        error_s  = 1'b0;
        case (next_state_s)
            ST_SUBX: begin
                sub_xy_s = 1'b1;
            end
            ST_SUBY: begin
                sub_yx_s = 1'b1;
            end
            ST_DONE: begin
                halt_s   = 1'b1;
                out_en_s = 1'b1;
            end
            ST_ERR: begin
                halt_s  = 1'b1;
                error_s = 1'b1;
            end
            default: begin
                sub_xy_s = 1'b0;
                sub_yx_s = 1'b0;
                out_en_s = 1'b0;
                halt_s   = 1'b0;
                error_s  = 1'b0;
            end
        endcase
    end

    // Registered Moore outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sub_xy_r <= 1'b0;
            sub_yx_r <= 1'b0;
            out_en_r <= 1'b0;
            halt_r   <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            sub_xy_r <= sub_xy_s;
            sub_yx_r <= sub_yx_s;
            out_en_r <= out_en_s;
            halt_r   <= halt_s;
            error_r  <= error_s;
        end
    end

    // Subtraction counter: cleared on every entry to WAITX, saturating at the limit.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            iter_count_r <= {ITER_W{1'b0}};
        end else if (next_state_s == ST_WAITX) begin
            iter_count_r <= {ITER_W{1'b0}};
        end else if (((state_r == ST_SUBX) || (state_r == ST_SUBY)) && (iter_count_r != MAX_ITER_C)) begin
            iter_count_r <= iter_count_r + ITER_W'(1'b1);
        end else begin
            iter_count_r <= iter_count_r;
        end
    end

    assign bus.LoadX     = load_x_s;
    assign bus.LoadY     = load_y_s;
    assign bus.SubXY     = sub_xy_r;
    assign bus.SubYX     = sub_yx_r;
    assign bus.OutEn     = out_en_r;
    assign bus.Halt      = halt_r;
    assign bus.Error     = error_r;
    assign bus.IterCount = iter_count_r;
    assign bus.State     = state_r;

endmodule

// File: tb/tb_gcd_control_unit.sv
// Bench for gcd_control_unit: behavioural datapath plus an arithmetic GCD reference model,
// directed corner cases and randomized operand pairs.
module tb_gcd_control_unit;
    localparam int ITER_W   = 4;
    localparam int MAX_ITER = 4;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] din;
    logic [7:0] x_r;
    logic [7:0] y_r;
    logic [7:0] out_r;

    int n_checks  = 0;
    int n_pass    = 0;
    int cyc       = 0;
    int subxy_cnt = 0;
    int subyx_cnt = 0;
    int loadx_cnt = 0;
    int loady_cnt = 0;
    int multi_cnt = 0;
    int halt_cyc  = -1;
    logic halt_q  = 1'b0;

    always #5 Clock = ~Clock;

    gcd_control_unit_if #(.ITER_W(ITER_W)) bus ();

    gcd_control_unit #(.ITER_W(ITER_W), .MAX_ITER(MAX_ITER)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    assign bus.InZero = (din == 8'd0);
    assign bus.XeqY   = (x_r == y_r);
    assign bus.XgtY   = (x_r > y_r);

    // Behavioural datapath: X/Y registers, subtractor and output register.
    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            x_r   <= 8'd0;
            y_r   <= 8'd0;
            out_r <= 8'd0;
        end else begin
            if (bus.LoadX) x_r <= din;
            if (bus.LoadY) y_r <= din;
            if (bus.SubXY) x_r <= x_r - y_r;
            if (bus.SubYX) y_r <= y_r - x_r;
            if (bus.OutEn) out_r <= x_r;
        end
    end

    // Cycle counter, strobe tallies and Halt rising-cycle capture.
    always @(posedge Clock) begin
        cyc       <= cyc + 1;
        subxy_cnt <= subxy_cnt + int'(bus.SubXY);
        subyx_cnt <= subyx_cnt + int'(bus.SubYX);
        loadx_cnt <= loadx_cnt + int'(bus.LoadX);
        loady_cnt <= loady_cnt + int'(bus.LoadY);
        if ((int'(bus.LoadX) + int'(bus.LoadY) + int'(bus.SubXY) + int'(bus.SubYX)) > 1)
            multi_cnt <= multi_cnt + 1;
        if (bus.Halt && !halt_q) halt_cyc <= cyc;
        halt_q <= bus.Halt;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: Euclid by subtraction, stopping at the iteration limit.
    task automatic ref_gcd(input int a, input int b, output int g, output int k,
                           output int nxy, output int nyx, output int err);
        k = 0; nxy = 0; nyx = 0; err = 0;
        while (a != b) begin
            if (k == MAX_ITER) begin
                err = 1;
                break;
            end
            if (a > b) begin a = a - b; nxy++; end
            else       begin b = b - a; nyx++; end
            k++;
        end
        g = a;
    endtask

    // One Enter press: assert for one cycle with operand v, report the load strobes seen.
    task automatic press(input logic [7:0] v, output int lx, output int ly, output int c);
        @(negedge Clock);
        din       = v;
        bus.Enter = 1'b1;
        #1;
        lx = int'(bus.LoadX);
        ly = int'(bus.LoadY);
        c  = cyc;
        @(negedge Clock);
        bus.Enter = 1'b0;
    endtask

    task automatic restart(input string tag);
        int lx, ly, c;
        press(8'd5, lx, ly, c);
        check_eq({tag, ".restart_noload"}, lx + ly, 0);
        check_eq({tag, ".restart_state"}, int'(bus.State), 1);
        check_eq({tag, ".restart_halt"}, int'(bus.Halt), 0);
        check_eq({tag, ".restart_iter"}, int'(bus.IterCount), 0);
    endtask

    task automatic run_pair(input int a, input int b, input string tag);
        int lx, ly, c0, c, g, k, nxy, nyx, err, sx0, sy0, wn;
        ref_gcd(a, b, g, k, nxy, nyx, err);
        check_eq({tag, ".start_state"}, int'(bus.State), 1);
        press(a[7:0], lx, ly, c0);
        check_eq({tag, ".loadx"}, lx, 1);
        press(b[7:0], lx, ly, c);
        check_eq({tag, ".loady"}, ly, 1);
        sx0 = subxy_cnt;
        sy0 = subyx_cnt;
        wn  = 0;
        while (!bus.Halt && wn < 100) begin
            @(negedge Clock);
            wn++;
        end
        check_eq({tag, ".halt_seen"}, int'(bus.Halt), 1);
        @(negedge Clock);
        check_eq({tag, ".halt_cycle"}, halt_cyc, c + 2 + 2 * k);
        check_eq({tag, ".error"}, int'(bus.Error), err);
        check_eq({tag, ".outen"}, int'(bus.OutEn), 1 - err);
        check_eq({tag, ".iter"}, int'(bus.IterCount), k);
        check_eq({tag, ".n_subxy"}, subxy_cnt - sx0, nxy);
        check_eq({tag, ".n_subyx"}, subyx_cnt - sy0, nyx);
        if (err == 0) check_eq({tag, ".output"}, int'(out_r), g);
        restart(tag);
    endtask

    initial begin
        int lx, ly, c, lx0, ly0, wn;
        Reset     = 1'b1;
        bus.Enter = 1'b0;
        din       = 8'd0;
        repeat (2) @(negedge Clock);
        check_eq("rst.state", int'(bus.State), 0);
        check_eq("rst.halt", int'(bus.Halt), 0);
        check_eq("rst.error", int'(bus.Error), 0);
        check_eq("rst.iter", int'(bus.IterCount), 0);
        check_eq("rst.strobes", int'(bus.SubXY) + int'(bus.SubYX) + int'(bus.OutEn), 0);
        Reset = 1'b0;
        @(negedge Clock);
        check_eq("init.to_waitx", int'(bus.State), 1);

        run_pair(12, 18, "g12_18");
        run_pair(7, 7, "g7_7");
        run_pair(127, 1, "limit127_1");

        // Zero X operand.
        press(8'd0, lx, ly, c);
        check_eq("zx.noload", lx, 0);
        check_eq("zx.state", int'(bus.State), 7);
        check_eq("zx.halt", int'(bus.Halt), 1);
        check_eq("zx.error", int'(bus.Error), 1);
        check_eq("zx.outen", int'(bus.OutEn), 0);
        restart("zx");
        run_pair(9, 6, "after_zero");

        // Enter held for 10 cycles in WAITX, then held again in WAITY.
        lx0 = loadx_cnt;
        ly0 = loady_cnt;
        @(negedge Clock);
        din       = 8'd11;
        bus.Enter = 1'b1;
        repeat (10) @(negedge Clock);
        check_eq("hold.loadx_once", loadx_cnt - lx0, 1);
        check_eq("hold.state_waity", int'(bus.State), 2);
        check_eq("hold.no_loady", loady_cnt - ly0, 0);
        bus.Enter = 1'b0;
        press(8'd0, lx, ly, c);
        check_eq("zy.noload", ly, 0);
        check_eq("zy.state", int'(bus.State), 7);
        check_eq("zy.error", int'(bus.Error), 1);
        restart("zy");

        // Asynchronous reset in the middle of a SUBX cycle.
        press(8'd100, lx, ly, c);
        press(8'd3, lx, ly, c);
        wn = 0;
        while (bus.State != 4'd4 && wn < 20) begin
            @(negedge Clock);
            wn++;
        end
        check_eq("mid.in_subx", int'(bus.State), 4);
        #2 Reset = 1'b1;
        #1;
        check_eq("mid.state", int'(bus.State), 0);
        check_eq("mid.outs", int'(bus.SubXY) + int'(bus.SubYX) + int'(bus.Halt) +
                 int'(bus.Error) + int'(bus.OutEn) + int'(bus.LoadX) + int'(bus.LoadY), 0);
        check_eq("mid.iter", int'(bus.IterCount), 0);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        run_pair(12, 18, "after_reset");

        // Randomized operand pairs.
        for (int i = 0; i < 16; i++) begin
            int a, b;
            a = int'($urandom_range(1, 24));
            b = int'($urandom_range(1, 24));
            run_pair(a, b, $sformatf("rnd%0d_%0d_%0d", i, a, b));
        end

        check_eq("onehot_strobes", multi_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/gcd_control_unit.md
# gcd_control_unit

Control FSM that sequences the subtract-and-compare GCD datapath of the EC2 processor. It does the following:
- accepts two operands through the Enter/Input handshake;
- drives the load and subtract strobes of the X/Y registers until X equals Y;
- raises Halt with Output enabled.

It also rejects zero operands and aborts runaway iterations with an error flag. The datapath (X/Y registers, subtractor, comparator, output mux) is a separate block; this unit only consumes its status flags.

## Interface
Parameters:
- ITER_W, 8, width of the subtraction counter
- MAX_ITER, 255, subtraction limit; must be < 2^ITER_W

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Enter  in  1  operand-valid level from user/bench; only its rising edge counts
- InZero  in  1  datapath flag: Input == 0
- XeqY  in  1  datapath flag: X == Y (from registered X, Y)
- XgtY  in  1  datapath flag: X > Y
- LoadX  out  1  X <= Input at next edge
- LoadY  out  1  Y <= Input at next edge
- SubXY  out  1  X <= X - Y at next edge
- SubYX  out  1  Y <= Y - X at next edge
- OutEn  out  1  Output <= X
- Halt  out  1  computation finished (result or error)
- Error  out  1  zero operand or iteration limit hit
- IterCount  out  ITER_W  subtractions performed in current run
- State  out  4  current state encoding, for display/debug

## Operation
- Edge detect: EnterQ <= Enter each cycle. EnterRise = Enter & ~EnterQ. EnterQ resets to 1, so an Enter held through reset is ignored until it is released and re-asserted.
- States: INIT=0, WAITX=1, WAITY=2, COMPARE=3, SUBX=4, SUBY=5, DONE=6, ERR=7. Other codes go to INIT.
- INIT: one cycle, then WAITX. EnterRise is ignored.
- WAITX: on EnterRise with InZero go to ERR. On EnterRise without InZero, pulse LoadX and go to WAITY. IterCount clears on entry.
- WAITY: same as WAITX, but pulses LoadY and goes to COMPARE.
- COMPARE:
  - If XeqY, go to DONE.
  - Else if IterCount == MAX_ITER, go to ERR.
  - Else if XgtY, go to SUBX; otherwise go to SUBY.
- SUBX / SUBY: assert SubXY / SubYX for exactly that cycle, increment IterCount, return to COMPARE.
- DONE: Halt=1, OutEn=1. EnterRise goes to WAITX, starting a new computation.
- ERR: Halt=1, Error=1, OutEn=0. EnterRise goes to WAITX.
- LoadX and LoadY are Mealy outputs (state & EnterRise & ~InZero). All other outputs are Moore, decoded from State.
- At most one of LoadX, LoadY, SubXY, SubYX is high in any cycle.
- IterCount saturates at MAX_ITER and never wraps.
- EnterRise in COMPARE, SUBX or SUBY is ignored. The computation cannot be interrupted except by Reset.

## Timing
- Reset values: State=INIT, EnterQ=1, IterCount=0. All strobes, Halt, Error and OutEn are 0.
- Reset asserted mid-computation returns to INIT immediately (asynchronously). Operands must then be re-entered; datapath register contents are don't-care.
- Operand capture: LoadX/LoadY are high in the same cycle as EnterRise. The register updates at the following edge.
- Flags XeqY/XgtY are valid in COMPARE because every SUB state is followed by COMPARE. Each subtraction therefore costs 2 cycles.
- Latency: with cycle t the WAITY cycle where LoadY is high and k subtractions, Halt rises in cycle t + 2 + 2k and stays high until the next EnterRise.
- Error latency:
  - Zero operand: ERR entered at the edge after the EnterRise, so Halt and Error are high 1 cycle later.
  - Iteration limit: ERR entered from COMPARE after the MAX_ITER-th subtraction.
- Minimum Enter spacing is none: a release and re-assert 2 cycles apart is accepted.

## Test plan
- X=12, Y=18 with a behavioural datapath model → SubYX then SubXY; Halt at t+6; Output=6; IterCount=2; Error=0.
- X=7, Y=7 → no Sub strobes; Halt at t+2; Output=7; IterCount=0.
- X=0 → ERR: Halt=1, Error=1, no LoadX. Next EnterRise with X=9 returns to WAITX and loads normally.
- Enter held high for 10 cycles in WAITX → exactly one LoadX pulse. Staying in WAITY requires release and re-assert.
- MAX_ITER=4, X=127, Y=1 → four SubXY strobes, then ERR with IterCount=4, Halt=1, Error=1.
- Reset asserted during SUBX of X=100, Y=3 → State=0 and all outputs 0 immediately. Re-entering 12/18 yields Output=6.
